// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - resolves carry-save beats and accumulates groups into a signed total
// Optional clamping of every accumulator update is enabled by defining CSA_ACC_SAT_EN.
module csa_accumulator #(
  parameter int IN_WIDTH  = 20,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [IN_WIDTH-1:0]  in_i [0:1],
  input  logic [CNT_WIDTH-1:0] len_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACC_WIDTH-1:0] out_o,
  output logic                 out_sat_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                 state;
  logic [ACC_WIDTH-1:0]   acc;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   len_q;

  logic [IN_WIDTH-1:0]    beat;
  logic [ACC_WIDTH-1:0]   s_ext;
  logic [ACC_WIDTH-1:0]   base;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic [CNT_WIDTH-1:0]   len_eff;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic                   start;

  // Rows are summed at their native width first; only the resolved beat is sign-extended.
  always_comb begin
    beat    = in_i[0] + in_i[1];
    s_ext   = ACC_WIDTH'($signed(beat));
    base    = (state == ACCUM) ? acc : '0;
    len_eff = (len_i == '0) ? CNT_WIDTH'(1) : len_i;
    cnt_inc = cnt + CNT_WIDTH'(1);
  end

  // A new group starts from IDLE, or from HOLD in the same cycle the result is handed off.
  assign in_ready_o  = (state != HOLD) || out_ready_i;
  assign start       = in_valid_i && ((state == IDLE) || ((state == HOLD) && out_ready_i));
  assign out_valid_o = (state == HOLD);
  assign out_o       = acc;

`ifdef CSA_ACC_SAT_EN
  logic [ACC_WIDTH:0] sum_wide;
  logic               ovf;
  logic               sat_q;

  always_comb begin
    sum_wide = {base[ACC_WIDTH-1], base} + {s_ext[ACC_WIDTH-1], s_ext};
    ovf      = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    if (!ovf)
      acc_next = sum_wide[ACC_WIDTH-1:0];
    else if (sum_wide[ACC_WIDTH])
      acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else
      acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

  assign out_sat_o = sat_q;
`else
  always_comb begin
    acc_next = base + s_ext;
  end

  assign out_sat_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
`ifdef CSA_ACC_SAT_EN
      sat_q <= 1'b0;
`endif
    end else if (start) begin
      acc   <= acc_next;
      len_q <= len_eff;
      cnt   <= CNT_WIDTH'(1);
      state <= (len_eff == CNT_WIDTH'(1)) ? HOLD : ACCUM;
`ifdef CSA_ACC_SAT_EN
      sat_q <= ovf;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid_i) begin
            acc <= acc_next;
            cnt <= cnt_inc;
`ifdef CSA_ACC_SAT_EN
            sat_q <= sat_q | ovf;
`endif
            if (cnt_inc == len_q)
              state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready_i)
            state <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - directed table-driven bench for csa_accumulator
module tb_csa_accumulator;
  localparam int IW  = 20;
  localparam int AW  = 32;
  localparam int CW  = 8;
  localparam int AW2 = 21;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [IW-1:0] rows [0:1];
  logic [CW-1:0] len;
  logic [AW-1:0] out;

  logic           s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_sat;
  logic [IW-1:0]  s_rows [0:1];
  logic [CW-1:0]  s_len;
  logic [AW2-1:0] s_out;

  csa_accumulator #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_i(rows), .len_i(len), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_o(out), .out_sat_o(out_sat)
  );

  csa_accumulator #(.IN_WIDTH(IW), .ACC_WIDTH(AW2), .CNT_WIDTH(CW)) dut_sat (
    .clk_i(clk), .rst_i(rst), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .in_i(s_rows), .len_i(s_len), .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
    .out_o(s_out), .out_sat_o(s_out_sat)
  );

  typedef struct {
    logic          v;
    logic [IW-1:0] a;
    logic [IW-1:0] b;
    logic [CW-1:0] len;
    logic          ordy;
    logic          e_ird;
    logic          e_ov;
    logic [AW-1:0] e_out;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [IW-1:0] a, input logic [IW-1:0] b,
                              input logic [CW-1:0] l, input logic ordy, input logic e_ird,
                              input logic e_ov, input logic [AW-1:0] e_out);
    vec_t r;
    r.v = v; r.a = a; r.b = b; r.len = l; r.ordy = ordy;
    r.e_ird = e_ird; r.e_ov = e_ov; r.e_out = e_out;
    return r;
  endfunction

  logic [AW2-1:0] exp_sat_out;
  logic           exp_sat_flag;

  initial begin
    // basic group: 8 + (-1) + 0 = 7
    vecs.push_back(mk(1, 20'h00005, 20'h00003, 8'd3, 1, 1, 0, 32'd8));
    vecs.push_back(mk(1, 20'hFFFFF, 20'h00000, 8'd3, 1, 1, 0, 32'd7));
    vecs.push_back(mk(1, 20'h80000, 20'h80000, 8'd3, 1, 1, 1, 32'd7));
    vecs.push_back(mk(0, 20'h00000, 20'h00000, 8'd0, 1, 1, 0, 32'd7));
    // backpressure: same group, result held five cycles while a beat is offered
    vecs.push_back(mk(1, 20'h00005, 20'h00003, 8'd3, 0, 1, 0, 32'd8));
    vecs.push_back(mk(1, 20'hFFFFF, 20'h00000, 8'd3, 0, 1, 0, 32'd7));
    vecs.push_back(mk(1, 20'h80000, 20'h80000, 8'd3, 0, 1, 1, 32'd7));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 20'h00009, 20'h00000, 8'd1, 0, 0, 1, 32'd7));
    vecs.push_back(mk(0, 20'h00000, 20'h00000, 8'd1, 1, 1, 0, 32'd7));
    // back-to-back singles
    vecs.push_back(mk(1, 20'h00001, 20'h00000, 8'd1, 1, 1, 1, 32'd1));
    vecs.push_back(mk(1, 20'h00002, 20'h00000, 8'd1, 1, 1, 1, 32'd2));
    vecs.push_back(mk(1, 20'h00003, 20'h00000, 8'd1, 1, 1, 1, 32'd3));
    vecs.push_back(mk(0, 20'h00000, 20'h00000, 8'd1, 1, 1, 0, 32'd3));
    // zero length, rows that only resolve to -4 when summed before extension
    vecs.push_back(mk(1, 20'h7FFFE, 20'h7FFFE, 8'd0, 1, 1, 1, 32'hFFFFFFFC));
    vecs.push_back(mk(0, 20'h00000, 20'h00000, 8'd0, 1, 1, 0, 32'hFFFFFFFC));
    // idle gap inside a group, len ignored after first beat
    vecs.push_back(mk(1, 20'h00001, 20'h00001, 8'd2, 1, 1, 0, 32'd2));
    vecs.push_back(mk(0, 20'h00000, 20'h00000, 8'd2, 1, 1, 0, 32'd2));
    vecs.push_back(mk(1, 20'h00003, 20'h00000, 8'd7, 1, 1, 1, 32'd5));
    vecs.push_back(mk(0, 20'h00000, 20'h00000, 8'd0, 1, 1, 0, 32'd5));

`ifdef CSA_ACC_SAT_EN
    exp_sat_out  = 21'h0FFFFF;
    exp_sat_flag = 1'b1;
`else
    exp_sat_out  = 21'h17FFFD;
    exp_sat_flag = 1'b0;
`endif

    rst = 1'b1;
    in_valid = 0; rows[0] = '0; rows[1] = '0; len = '0; out_ready = 1;
    s_in_valid = 0; s_rows[0] = '0; s_rows[1] = '0; s_len = '0; s_out_ready = 1;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out", out, 32'd0);
    chk("reset_out_sat", 32'(out_sat), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = vecs[i].v; rows[0] = vecs[i].a; rows[1] = vecs[i].b;
      len = vecs[i].len; out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ird));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_out", i), out, vecs[i].e_out);
      chk($sformatf("v%0d_out_sat", i), 32'(out_sat), 32'd0);
      @(negedge clk);
    end

    // saturation on the narrow instance
    s_in_valid = 1; s_rows[0] = 20'h7FFFF; s_rows[1] = '0; s_len = 8'd3;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("sat_partial_out", 32'(s_out), 32'h000FFFFE);
    chk("sat_partial_flag", 32'(s_out_sat), 32'd0);
    @(posedge clk);
    #1;
    chk("sat_out_valid", 32'(s_out_valid), 32'd1);
    chk("sat_out", 32'(s_out), 32'(exp_sat_out));
    chk("sat_flag", 32'(s_out_sat), 32'(exp_sat_flag));
    @(negedge clk);
    s_in_valid = 0;
    @(posedge clk);
    #1;
    chk("sat_out_valid_done", 32'(s_out_valid), 32'd0);

    // reset mid-group
    @(negedge clk);
    in_valid = 1; rows[0] = 20'h00003; rows[1] = '0; len = 8'd4; out_ready = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midrst_partial", out, 32'd6);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out", out, 32'd0);
    chk("midrst_out_sat", 32'(out_sat), 32'd0);
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1; rows[0] = 20'h00005; rows[1] = '0; len = 8'd1;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd1);
    chk("post_rst_out", out, 32'd5);
    @(negedge clk);
    in_valid = 0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
